cla_seq_adder: RTL and testbench
================================

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NSLICE = WIDTH/4: number of 4-bit carry-lookahead slices, and the compute latency in cycles.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 in_valid  input  1: operands present.
REQ-006 in_ready  output  1: block can accept operands.
REQ-007 A, B  input  WIDTH each: unsigned/two's-complement operands.
REQ-008 cin  input  1: carry into bit 0.
REQ-009 out_valid  output  1: result present.
REQ-010 out_ready  input  1: consumer takes the result.
REQ-011 sum  output  WIDTH: A+B+cin modulo 2^WIDTH.
REQ-012 cout  output  1: carry out of bit WIDTH-1.
REQ-013 ovf  output  1: signed overflow; present only under REQ-030.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0; when in_valid&in_ready is high at an edge, the block SHALL latch A, B and cin, clear the slice counter k, and go to RUN.
REQ-016 RUN: on each edge, slice k SHALL be computed with 4-bit lookahead logic (P=a^b, G=a&b, C1..C4 from G, P and the carry register) into sum[4k+3:4k]; the carry register SHALL take C4 and k SHALL increment.
REQ-017 After the edge that computes slice NSLICE-1, the FSM SHALL go to DONE, and cout SHALL equal the final C4.
REQ-018 Latency: out_valid SHALL rise exactly NSLICE cycles after the accepting edge (4 cycles for WIDTH=16).
REQ-019 DONE: out_valid=1; sum, cout and ovf SHALL be held stable until out_valid&out_ready is sampled high, after which the FSM goes to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored in those states, and operand changes SHALL NOT affect the computation in flight.
REQ-021 The block SHALL NOT accept new operands on the edge that retires a result; in_ready rises in the cycle after the DONE handshake (back-to-back throughput is one result per NSLICE+2 cycles).
REQ-022 out_ready high while in IDLE or RUN SHALL have no effect.
REQ-023 sum bits not yet computed in RUN are don't-care; only values shown while out_valid=1 are architectural.
REQ-024 The k counter SHALL be $clog2(NSLICE) bits wide (minimum 1 bit) and SHALL NOT wrap within one operation.

Reset
REQ-025 While rst=1 at an edge, the FSM SHALL go to IDLE and sum, cout, ovf, the carry register and k SHALL be cleared to 0.
REQ-026 In the cycle after reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no result produced; a pending out_valid SHALL drop.
REQ-028 If rst and in_valid are high at the same edge, rst SHALL win and the operands SHALL NOT be accepted.

Configuration
REQ-029 The macro CLA_SEQ_OVF_EN SHALL control signed-overflow support.
REQ-030 With CLA_SEQ_OVF_EN defined, port ovf SHALL exist and be set in DONE to A[W-1]~^B[W-1] & (sum[W-1]^A[W-1]), where W=WIDTH; it SHALL be cleared by reset.
REQ-031 With CLA_SEQ_OVF_EN undefined, port ovf and all of its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=16, A=0xFFFF, B=0x0001, cin=0 -> out_valid 4 cycles after accept; sum=0x0000, cout=1.
REQ-033 WIDTH=16, A=0x1234, B=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 throughout RUN and DONE.
REQ-034 Backpressure: out_ready held low for 3 cycles in DONE -> sum, cout and out_valid held stable; out_ready high -> IDLE, with in_ready=1 on the next cycle.
REQ-035 rst pulsed at RUN k=2 -> next cycle in_ready=1, out_valid=0, sum=0; a new operation then completes correctly.
REQ-036 WIDTH=32, A=0xFFFFFFFF, B=0, cin=1 -> sum=0, cout=1, latency 8 cycles.
REQ-037 CLA_SEQ_OVF_EN defined, WIDTH=16, A=0x7FFF, B=0x0001 -> sum=0x8000, ovf=1; then A=0xFFFF, B=0x0001 -> ovf=0.

Source files
------------

// File: rtl/cla_seq_adder.sv
// Sequential adder that resolves one 4-bit carry-lookahead slice per clock, LSB slice first.
// Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [KW-1:0]    r_k;
`ifdef CLA_SEQ_OVF_EN
    logic             r_ovf;
`endif

    logic [KW+1:0]    w_base;
    logic [3:0]       w_a;
    logic [3:0]       w_b;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [3:0]       w_s;
    logic [4:0]       w_c;
    logic             w_last;

    // Lookahead for the slice selected by k; carries come from G/P and the carry register only.
    always_comb begin
        w_base = {r_k, 2'b00};
        w_a    = r_a[w_base +: 4];
        w_b    = r_b[w_base +: 4];
        w_p    = w_a ^ w_b;
        w_g    = w_a & w_b;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_s    = w_p ^ w_c[3:0];
        w_last = (r_k == KW'(NSLICE - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= A;
                        r_b        <= B;
                        r_carry    <= cin;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[w_base +: 4] <= w_s;
                    r_carry            <= w_c[4];
                    if (w_last) begin
                        r_cout      <= w_c[4];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef CLA_SEQ_OVF_EN
                        // w_s[3] is the sum MSB being written on this same edge.
                        r_ovf <= (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (w_s[3] ^ r_a[WIDTH-1]);
`endif
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: WIDTH=16 table and random vectors, plus a WIDTH=32 instance.
// Expectations come from plain integer arithmetic on the operands.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, ir, ov, ordy, cin, co;
    logic [15:0] a, b, s;
    logic        iv32, ir32, ov32, ordy32, cin32, co32;
    logic [31:0] a32, b32, s32;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf16, ovf32;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .A(a), .B(b), .cin(cin),
        .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co)
`ifdef CLA_SEQ_OVF_EN
        , .ovf(ovf16)
`endif
    );

    cla_seq_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32), .cin(cin32),
        .out_valid(ov32), .out_ready(ordy32), .sum(s32), .cout(co32)
`ifdef CLA_SEQ_OVF_EN
        , .ovf(ovf32)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        int          holds;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {ovf, cout, sum} from integer arithmetic
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] u;
        int          ss;
        logic        o;
        u  = {1'b0, x} + {1'b0, y} + {16'd0, c};
        ss = int'(signed'(x)) + int'(signed'(y)) + int'(c);
        o  = (ss > 32767) || (ss < -32768);
        return {o, u};
    endfunction

    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input int holds, input logic [15:0] es,
                         input logic ec, input logic eovf);
        int   lat;
        logic busy_ok;
        logic [15:0] s0;
        check({tag, ".in_ready_idle"}, 64'(ir), 64'd1);
        a = ta; b = tb_; cin = tc; iv = 1'b1;
        step();
        lat = 0;
        busy_ok = 1'b1;
        while (!ov && lat < 50) begin
            if (ir) busy_ok = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            iv = 1'($urandom); ordy = 1'($urandom);
            step();
            lat++;
        end
        ordy = 1'b0;
        iv = 1'b1;
        check({tag, ".latency"}, 64'(lat), 64'd4);
        check({tag, ".in_ready_run"}, 64'(busy_ok), 64'd1);
        check({tag, ".sum"}, 64'(s), 64'(es));
        check({tag, ".cout"}, 64'(co), 64'(ec));
`ifdef CLA_SEQ_OVF_EN
        check({tag, ".ovf"}, 64'(ovf16), 64'(eovf));
`else
        if (eovf === 1'bx) $display("note: %s has unknown ovf expectation", tag);
`endif
        s0 = s;
        for (int h = 0; h < holds; h++) begin
            a = 16'($urandom); b = 16'($urandom);
            step();
            check({tag, ".hold"}, {ov, ir, co, s}, {1'b1, 1'b0, ec, s0});
        end
        ordy = 1'b1;
        step();
        ordy = 1'b0;
        iv = 1'b0;
        check({tag, ".retire"}, {ov, ir}, {1'b0, 1'b1});
    endtask

    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc);
        int          lat;
        logic [32:0] u;
        u = {1'b0, ta} + {1'b0, tb_} + {32'd0, tc};
        check({tag, ".in_ready_idle"}, 64'(ir32), 64'd1);
        a32 = ta; b32 = tb_; cin32 = tc; iv32 = 1'b1;
        step();
        iv32 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        lat = 0;
        while (!ov32 && lat < 50) begin
            step();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd8);
        check({tag, ".sum"}, 64'(s32), 64'(u[31:0]));
        check({tag, ".cout"}, 64'(co32), 64'(u[32]));
        ordy32 = 1'b1;
        step();
        ordy32 = 1'b0;
        check({tag, ".retire"}, {ov32, ir32}, {1'b0, 1'b1});
    endtask

    initial begin
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rc;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 3, 16'h5556, 1'b0, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 2, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0F0F, 16'h00F1, 1'b0, 3, 16'h1000, 1'b0, 1'b0};

        rst = 1'b1; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; cin = 1'b0;
        iv32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;
        check("reset.state16", {ir, ov, co, s}, {1'b1, 1'b0, 1'b0, 16'h0000});
        check("reset.state32", {ir32, ov32, co32, s32}, {1'b1, 1'b0, 1'b0, 32'h0});
`ifdef CLA_SEQ_OVF_EN
        check("reset.ovf", 64'(ovf16), 64'd0);
`endif

        // reset wins over a simultaneous in_valid
        rst = 1'b1; iv = 1'b1; a = 16'h1111; b = 16'h2222;
        step();
        rst = 1'b0; iv = 1'b0;
        repeat (6) step();
        check("rst_vs_valid", {ir, ov}, {1'b1, 1'b0});

        foreach (tbl[i])
            run16($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].holds,
                  tbl[i].s, tbl[i].co, tbl[i].ov);

        // abort at RUN with k=2
        a = 16'hABCD; b = 16'h1357; cin = 1'b1; iv = 1'b1;
        step();
        iv = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.state", {ir, ov, s}, {1'b1, 1'b0, 16'h0000});
        repeat (6) step();
        check("abort.no_result", 64'(ov), 64'd0);
        m = model16(16'hABCD, 16'h1357, 1'b1);
        run16("after_abort", 16'hABCD, 16'h1357, 1'b1, 0, m[15:0], m[16], m[17]);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            m = model16(ra, rb, rc);
            run16($sformatf("rnd%0d", i), ra, rb, rc, int'($urandom_range(0, 2)),
                  m[15:0], m[16], m[17]);
        end

        run32("w32_max", 32'hFFFFFFFF, 32'h0, 1'b1);
        run32("w32_mix", 32'h89ABCDEF, 32'h76543210, 1'b0);
        run32("w32_rnd", $urandom, $urandom, 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
